// File: rtl/data_memory_unit_pkg.sv
// mem_defs: shared size encodings, FSM state encoding and lane-count derivation
// for data_memory_unit and its load aligner.
package mem_defs;

   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_HALF  = 2'b01;
   localparam logic [1:0] SZ_WORD  = 2'b10;
   localparam logic [1:0] SZ_DWORD = 2'b11;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SPLIT = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;

   function automatic int lane_count(input int word_length);
      return word_length / 8;
   endfunction

endpackage

// File: rtl/data_memory_unit_load_align.sv
// mem_load_align: shifts the addressed bytes of a two-word window down to bit 0,
// trims them to the access size and sign- or zero-extends to WORD_LENGTH.
module mem_load_align
   import mem_defs::*;
#(
   parameter int WORD_LENGTH = 32
) (
   input  logic [WORD_LENGTH-1:0]                   lo_word,
   input  logic [WORD_LENGTH-1:0]                   hi_word,
   input  logic [$clog2(lane_count(WORD_LENGTH))-1:0] lane_off,
   input  logic [1:0]                               size,
   input  logic                                     is_unsigned,
   output logic [WORD_LENGTH-1:0]                   load_data
);

   logic [2*WORD_LENGTH-1:0] shifted;
   logic [WORD_LENGTH-1:0]   keep;
   logic                     fill;
   logic                     unused_high;

   always_comb begin
      shifted = {hi_word, lo_word} >> {lane_off, 3'b000};
      case (size)
         SZ_BYTE: begin keep = WORD_LENGTH'(8'hFF);         fill = shifted[7];  end
         SZ_HALF: begin keep = WORD_LENGTH'(16'hFFFF);      fill = shifted[15]; end
         SZ_WORD: begin keep = WORD_LENGTH'(32'hFFFF_FFFF); fill = shifted[31]; end
         default: begin keep = '1; fill = shifted[WORD_LENGTH-1]; end
      endcase
      if (is_unsigned) begin
         fill = 1'b0;
      end
      load_data = (shifted[WORD_LENGTH-1:0] & keep) | ({WORD_LENGTH{fill}} & ~keep);
   end

   assign unused_high = ^shifted[2*WORD_LENGTH-1:WORD_LENGTH];

endmodule

// File: rtl/data_memory_unit.sv
// data_memory_unit: byte-addressable load/store memory with valid/ready request and registered response.
// Define MISALIGNED_SPLIT_EN to run word-crossing accesses in two beats; otherwise they return resp_err.
module data_memory_unit
   import mem_defs::*;
#(
   parameter int WORD_LENGTH = 32,
   parameter int DEPTH       = 64,
   parameter int ADDR_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [1:0]             req_size,
   input  logic                   req_unsigned,
   input  logic [ADDR_WIDTH-1:0]  address,
   input  logic [WORD_LENGTH-1:0] write_data,
   output logic                   resp_valid,
   output logic                   resp_err,
   output logic [WORD_LENGTH-1:0] data_out
);

   localparam int LANES      = lane_count(WORD_LENGTH);
   localparam int LANE_BITS  = $clog2(LANES);
   localparam int IDX_BITS   = $clog2(DEPTH);
   localparam int WIDE_LANES = 2 * LANES;

   logic [1:0]             state_q, state_d;
   logic [WORD_LENGTH-1:0] mem_q [DEPTH];
   logic [WORD_LENGTH-1:0] mem_d [DEPTH];
   logic [WORD_LENGTH-1:0] data_out_q, data_out_d;
   logic                   resp_err_q, resp_err_d;

   logic                     accept, illegal, crossing;
   logic [LANE_BITS-1:0]     lane_off;
   logic [IDX_BITS-1:0]      word_idx;
   logic [WIDE_LANES-1:0]    size_mask, lane_mask;
   logic [2*WORD_LENGTH-1:0] wide_wdata;

   logic                   wr_en;
   logic [IDX_BITS-1:0]    wr_idx;
   logic [WORD_LENGTH-1:0] wr_data;
   logic [LANES-1:0]       wr_mask;

   logic [WORD_LENGTH-1:0] al_lo, al_hi, align_data;
   logic [LANE_BITS-1:0]   al_off;
   logic [1:0]             al_size;
   logic                   al_uns;
   logic                   unused_bits;

`ifdef MISALIGNED_SPLIT_EN
   // Beat-2 context: high half of the store, or the low word already fetched for a load.
   logic [IDX_BITS-1:0]    split_idx_q, split_idx_d;
   logic [WORD_LENGTH-1:0] split_hi_data_q, split_hi_data_d;
   logic [LANES-1:0]       split_hi_mask_q, split_hi_mask_d;
   logic                   split_write_q, split_write_d;
   logic [WORD_LENGTH-1:0] split_lo_q, split_lo_d;
   logic [LANE_BITS-1:0]   split_off_q, split_off_d;
   logic [1:0]             split_size_q, split_size_d;
   logic                   split_uns_q, split_uns_d;
`endif

   assign req_ready   = (state_q != SPLIT);
   assign resp_valid  = (state_q == RESP);
   assign resp_err    = resp_err_q;
   assign data_out    = data_out_q;
   assign accept      = req_valid && req_ready;
   assign lane_off    = address[LANE_BITS-1:0];
   assign word_idx    = address[LANE_BITS +: IDX_BITS];
   assign illegal     = (req_size == SZ_DWORD) && (WORD_LENGTH == 32);
   assign lane_mask   = size_mask << lane_off;
   assign wide_wdata  = {{WORD_LENGTH{1'b0}}, write_data} << {lane_off, 3'b000};
   assign crossing    = |lane_mask[WIDE_LANES-1:LANES];
   assign unused_bits = ^{address, wide_wdata};

   always_comb begin
      case (req_size)
         SZ_BYTE: size_mask = WIDE_LANES'(8'h01);
         SZ_HALF: size_mask = WIDE_LANES'(8'h03);
         SZ_WORD: size_mask = WIDE_LANES'(8'h0F);
         default: size_mask = WIDE_LANES'(8'hFF);
      endcase
   end

   mem_load_align #(
      .WORD_LENGTH (WORD_LENGTH)
   ) u_align (
      .lo_word     (al_lo),
      .hi_word     (al_hi),
      .lane_off    (al_off),
      .size        (al_size),
      .is_unsigned (al_uns),
      .load_data   (align_data)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      state_d    = state_q;
      data_out_d = '0;
      resp_err_d = 1'b0;
      wr_en      = 1'b0;
      wr_idx     = word_idx;
      wr_data    = wide_wdata[WORD_LENGTH-1:0];
      wr_mask    = lane_mask[LANES-1:0];
      al_lo      = mem_q[word_idx];
      al_hi      = '0;
      al_off     = lane_off;
      al_size    = req_size;
      al_uns     = req_unsigned;
`ifdef MISALIGNED_SPLIT_EN
      split_idx_d     = split_idx_q;
      split_hi_data_d = split_hi_data_q;
      split_hi_mask_d = split_hi_mask_q;
      split_write_d   = split_write_q;
      split_lo_d      = split_lo_q;
      split_off_d     = split_off_q;
      split_size_d    = split_size_q;
      split_uns_d     = split_uns_q;
`endif

      if (state_q == SPLIT) begin
`ifdef MISALIGNED_SPLIT_EN
         al_lo      = split_lo_q;
         al_hi      = mem_q[split_idx_q];
         al_off     = split_off_q;
         al_size    = split_size_q;
         al_uns     = split_uns_q;
         wr_en      = split_write_q;
         wr_idx     = split_idx_q;
         wr_data    = split_hi_data_q;
         wr_mask    = split_hi_mask_q;
         data_out_d = split_write_q ? '0 : align_data;
         state_d    = RESP;
`else
         state_d    = IDLE;
`endif
      end else if (accept) begin
         state_d = RESP;
         if (illegal) begin
            resp_err_d = 1'b1;
         end else if (crossing) begin
`ifdef MISALIGNED_SPLIT_EN
            state_d         = SPLIT;
            wr_en           = req_write;
            split_idx_d     = word_idx + IDX_BITS'(1);
            split_hi_data_d = wide_wdata[2*WORD_LENGTH-1:WORD_LENGTH];
            split_hi_mask_d = lane_mask[WIDE_LANES-1:LANES];
            split_write_d   = req_write;
            split_lo_d      = mem_q[word_idx];
            split_off_d     = lane_off;
            split_size_d    = req_size;
            split_uns_d     = req_unsigned;
`else
            resp_err_d = 1'b1;
`endif
         end else begin
            wr_en      = req_write;
            data_out_d = req_write ? '0 : align_data;
         end
      end else begin
         state_d = IDLE;
      end
   end

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         for (int j = 0; j < LANES; j++) begin
            if (wr_mask[j]) begin
               mem_d[wr_idx][j*8 +: 8] = wr_data[j*8 +: 8];
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         data_out_q <= '0;
         resp_err_q <= 1'b0;
         // NOTE: storage is a flop array, not a RAM macro, so reset can clear every byte.
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
`ifdef MISALIGNED_SPLIT_EN
         split_idx_q     <= '0;
         split_hi_data_q <= '0;
         split_hi_mask_q <= '0;
         split_write_q   <= 1'b0;
         split_lo_q      <= '0;
         split_off_q     <= '0;
         split_size_q    <= SZ_BYTE;
         split_uns_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         data_out_q <= data_out_d;
         resp_err_q <= resp_err_d;
         mem_q      <= mem_d;
`ifdef MISALIGNED_SPLIT_EN
         split_idx_q     <= split_idx_d;
         split_hi_data_q <= split_hi_data_d;
         split_hi_mask_q <= split_hi_mask_d;
         split_write_q   <= split_write_d;
         split_lo_q      <= split_lo_d;
         split_off_q     <= split_off_d;
         split_size_q    <= split_size_d;
         split_uns_q     <= split_uns_d;
`endif
      end
   end

endmodule

// File: tb/tb_data_memory_unit.sv
// Scoreboard bench for data_memory_unit; expectations follow MISALIGNED_SPLIT_EN when defined.
module tb_data_memory_unit;

`ifdef MISALIGNED_SPLIT_EN
   localparam bit SPLIT_ON = 1'b1;
`else
   localparam bit SPLIT_ON = 1'b0;
`endif

   logic        clk          = 1'b0;
   logic        rst          = 1'b1;
   logic        req_valid    = 1'b0;
   logic        req_write    = 1'b0;
   logic [1:0]  req_size     = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] address      = '0;
   logic [31:0] write_data   = '0;
   logic        req_ready;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] data_out;

   data_memory_unit #(
      .WORD_LENGTH (32),
      .DEPTH       (64),
      .ADDR_WIDTH  (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .address      (address),
      .write_data   (write_data),
      .resp_valid   (resp_valid),
      .resp_err     (resp_err),
      .data_out     (data_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
      int          lat;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst && resp_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_resp", 32'(resp_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            check({e.tag, "_data"}, data_out, e.data);
            check({e.tag, "_err"}, 32'(resp_err), 32'(e.err));
            check({e.tag, "_lat"}, 32'(cyc - e.cyc), 32'(e.lat));
         end
      end
   end

   task automatic send(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ee, input int lat);
      exp_t e;
      int   guard;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) check({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
      req_valid    = 1'b1;
      req_write    = wr;
      req_size     = sz;
      req_unsigned = uns;
      address      = a;
      write_data   = wd;
      e.data = ed;
      e.err  = ee;
      e.cyc  = cyc;
      e.lat  = lat;
      e.tag  = tag;
      sb.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check({tag, "_drain"}, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      #1 rst = 1'b0;
      #20;
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_valid", 32'(resp_valid), 32'd0);
      check("rst_err", 32'(resp_err), 32'd0);
      check("rst_data", data_out, 32'd0);
      @(negedge clk) rst = 1'b1;

      send("ld_w0",   1'b0, 2'b10, 1'b0, 32'h0, 32'h0,        32'h0000_0000, 1'b0, 1);
      send("st_w8",   1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF, 32'h0,        1'b0, 1);
      send("ld_b9s",  1'b0, 2'b00, 1'b0, 32'h9, 32'h0,        32'hFFFF_FFBE, 1'b0, 1);
      send("ld_b9u",  1'b0, 2'b00, 1'b1, 32'h9, 32'h0,        32'h0000_00BE, 1'b0, 1);
      send("ld_hAs",  1'b0, 2'b01, 1'b0, 32'hA, 32'h0,        32'hFFFF_DEAD, 1'b0, 1);
      send("ld_h9u",  1'b0, 2'b01, 1'b1, 32'h9, 32'h0,        32'h0000_ADBE, 1'b0, 1);
      send("st_h2",   1'b1, 2'b01, 1'b0, 32'h2, 32'h0000_1234, 32'h0,        1'b0, 1);
      send("ld_w0b",  1'b0, 2'b10, 1'b0, 32'h0, 32'h0,        32'h1234_0000, 1'b0, 1);
      drain("basic");

      send("st_x6",   1'b1, 2'b10, 1'b0, 32'h6, 32'hAABB_CCDD, 32'h0, !SPLIT_ON, SPLIT_ON ? 2 : 1);
      check("split_ready", 32'(req_ready), SPLIT_ON ? 32'd0 : 32'd1);
      send("ld_w6",   1'b0, 2'b10, 1'b0, 32'h6, 32'h0,
           SPLIT_ON ? 32'hAABB_CCDD : 32'h0, !SPLIT_ON, SPLIT_ON ? 2 : 1);
      send("ld_w4",   1'b0, 2'b10, 1'b0, 32'h4, 32'h0,
           SPLIT_ON ? 32'hCCDD_0000 : 32'h0, 1'b0, 1);
      send("ld_w8",   1'b0, 2'b10, 1'b0, 32'h8, 32'h0,
           SPLIT_ON ? 32'hDEAD_AABB : 32'hDEAD_BEEF, 1'b0, 1);
      send("st_d0",   1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
      send("ld_w0c",  1'b0, 2'b10, 1'b0, 32'h0, 32'h0,        32'h1234_0000, 1'b0, 1);
      send("ld_d8",   1'b0, 2'b11, 1'b0, 32'h8, 32'h0,        32'h0, 1'b1, 1);
      drain("split");

      send("st_hFF",  1'b1, 2'b01, 1'b0, 32'hFF, 32'h0000_A55A, 32'h0, !SPLIT_ON, SPLIT_ON ? 2 : 1);
      send("ld_b0u",  1'b0, 2'b00, 1'b1, 32'h0, 32'h0,
           SPLIT_ON ? 32'h0000_00A5 : 32'h0, 1'b0, 1);
      send("ld_bFFs", 1'b0, 2'b00, 1'b0, 32'hFF, 32'h0,
           SPLIT_ON ? 32'h0000_005A : 32'h0, 1'b0, 1);
      send("ld_w100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0,
           SPLIT_ON ? 32'h1234_00A5 : 32'h1234_0000, 1'b0, 1);
      drain("wrap");

      // Reset lands just after a crossing store is accepted; its response must never appear.
      send("st_xE",   1'b1, 2'b10, 1'b0, 32'hE, 32'h1122_3344, 32'h0, !SPLIT_ON, SPLIT_ON ? 2 : 1);
      rst = 1'b0;
      #2;
      check("rstsplit_valid", 32'(resp_valid), 32'd0);
      check("rstsplit_ready", 32'(req_ready), 32'd1);
      void'(sb.pop_back());
      rst = 1'b1;
      @(negedge clk);
      check("rstsplit_valid2", 32'(resp_valid), 32'd0);
      send("ld_wC",   1'b0, 2'b10, 1'b0, 32'hC,  32'h0, 32'h0, 1'b0, 1);
      send("ld_w10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1);
      send("ld_w0d",  1'b0, 2'b10, 1'b0, 32'h0,  32'h0, 32'h0, 1'b0, 1);
      drain("rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
